alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_pkg.sv | 56 +++++
 rtl/muldiv_iter.sv | 109 ++++++++++
 rtl/alu_multicycle.sv | 142 ++++++++++++++
 tb/tb_alu_multicycle.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, control states and default width.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package alu_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_SLL   = 5'd2,
    OP_SRL   = 5'd3,
    OP_SRA   = 5'd4,
    OP_SLT   = 5'd5,
    OP_SLTU  = 5'd6,
    OP_AND   = 5'd7,
    OP_OR    = 5'd8,
    OP_XOR   = 5'd9,
    OP_NOP   = 5'd10,
    OP_CMP   = 5'd11,
    OP_CMP_U = 5'd12,
    OP_ADDW  = 5'd13,
    OP_SUBW  = 5'd14,
    OP_MUL   = 5'd15,
    OP_MULH  = 5'd16,
    OP_MULHU = 5'd17,
    OP_DIV   = 5'd18,
    OP_DIVU  = 5'd19,
    OP_REM   = 5'd20,
    OP_REMU  = 5'd21
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_mul_op(alu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHU};
  endfunction

  function automatic logic is_div_op(alu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_iter_op(alu_op_e op);
    return is_mul_op(op) || is_div_op(op);
  endfunction

  // Ops whose iterative datapath works on magnitudes and fixes the sign at the end.
  function automatic logic is_signed_op(alu_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative multiply (shift-add) and restoring divide on magnitudes.
// Latency: exactly XLEN iteration cycles after i_start; o_done on the last one with o_result valid.
// Backpressure: none; i_flush aborts, i_start reloads. Ports: clk, rst_n, i_flush, i_start,
//   i_op, i_a, i_b (operands sampled at i_start), o_done (1-cycle pulse), o_result (valid with o_done).
module muldiv_iter import alu_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_start,
  input  alu_op_e         i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CNT_W = $clog2(XLEN);

  logic             r_active;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_hi;     // product high half / partial remainder
  logic [XLEN-1:0]  r_lo;     // multiplier shifting out / dividend shifting out, quotient shifting in
  logic [XLEN-1:0]  r_opd;    // multiplicand / divisor (magnitude for signed ops)
  alu_op_e          r_op;
  logic             r_neg_q;  // product or quotient must be negated
  logic             r_neg_r;  // remainder must be negated (follows dividend sign)

  logic            w_signed;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic [XLEN:0]   w_mul_sum, w_rem_sh, w_diff;
  logic            w_div_ge;
  logic [XLEN-1:0] w_hi_nx, w_lo_nx, w_mulh_neg;

  // Magnitudes only for signed ops; MUL low half is sign-agnostic so raw operands are used.
  always_comb begin
    w_signed = is_signed_op(i_op);
    w_a_mag  = (w_signed && i_a[XLEN-1]) ? -i_a : i_a;
    w_b_mag  = (w_signed && i_b[XLEN-1]) ? -i_b : i_b;
  end

  always_comb begin
    // Shift-add step: add multiplicand when the current multiplier bit is set, then shift right.
    w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
    // Restoring step: shift remainder left, bring in next dividend bit, subtract if it fits.
    w_rem_sh  = {r_hi, r_lo[XLEN-1]};
    w_diff    = w_rem_sh - {1'b0, r_opd};
    w_div_ge  = ~w_diff[XLEN];
    if (is_mul_op(r_op)) begin
      w_hi_nx = w_mul_sum[XLEN:1];
      w_lo_nx = {w_mul_sum[0], r_lo[XLEN-1:1]};
    end else begin
      w_hi_nx = w_div_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
      w_lo_nx = {r_lo[XLEN-2:0], w_div_ge};
    end
    // High half of the negated 2*XLEN product: ~hi plus the carry out of (~lo + 1).
    w_mulh_neg = ~w_hi_nx + XLEN'(w_lo_nx == '0);
  end

  assign o_done = r_active && (r_cnt == CNT_W'(XLEN - 1));

  always_comb begin
    o_result = '0;
    case (r_op)
      OP_MUL:           o_result = w_lo_nx;
      OP_MULHU:         o_result = w_hi_nx;
      OP_MULH:          o_result = r_neg_q ? w_mulh_neg : w_hi_nx;
      OP_DIV, OP_DIVU:  o_result = r_neg_q ? -w_lo_nx : w_lo_nx;
      OP_REM, OP_REMU:  o_result = r_neg_r ? -w_hi_nx : w_hi_nx;
      default:          o_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opd    <= '0;
      r_op     <= OP_ADD;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (i_flush) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= w_a_mag;
      r_opd    <= w_b_mag;
      r_op     <= i_op;
      r_neg_q  <= w_signed && (i_a[XLEN-1] ^ i_b[XLEN-1]);
      r_neg_r  <= w_signed && i_a[XLEN-1];
    end else if (r_active) begin
      r_hi <= w_hi_nx;
      r_lo <= w_lo_nx;
      if (o_done) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle ops and div special cases in place, MUL/DIV/REM via muldiv_iter.
// Latency: result valid 1 cycle after accept (single-cycle/special) or XLEN+1 cycles (iterative).
// Backpressure: in_ready only when idle; result held in DONE until out_ready; flush aborts.
// Ports: clk, rst_n (async low); in_valid/in_ready with alu_op, a, b; flush;
//   out_valid/out_ready with res and zero (res == 0, meaningful while out_valid).
module alu_multicycle import alu_pkg::*; #(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic            zero
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  alu_state_e      r_state, w_state_nx;
  logic [XLEN-1:0] r_res;

  alu_op_e         w_op;
  logic [SHAMT_W-1:0] w_shamt;
  logic [31:0]     w_sum32, w_dif32;
  logic            w_lt_s, w_lt_u, w_eq, w_b_zero, w_ovf, w_special, w_quick;
  logic [XLEN-1:0] w_quick_res, w_iter_res;
  logic            w_start, w_load_quick, w_load_iter, w_iter_done;

  assign w_op    = alu_op_e'(alu_op);
  assign w_shamt = b[SHAMT_W-1:0];

  always_comb begin
    w_sum32  = a[31:0] + b[31:0];
    w_dif32  = a[31:0] - b[31:0];
    w_lt_s   = $signed(a) < $signed(b);
    w_lt_u   = a < b;
    w_eq     = (a == b);
    w_b_zero = (b == '0);
    w_ovf    = (a == MOST_NEG) && (b == '1);
    // Divide-by-zero and signed overflow have fixed answers, so they never enter the iterator.
    w_special = is_div_op(w_op) && (w_b_zero || (is_signed_op(w_op) && w_ovf));
    w_quick   = !is_iter_op(w_op) || w_special;

    w_quick_res = '0;
    case (w_op)
      OP_ADD:   w_quick_res = a + b;
      OP_SUB:   w_quick_res = a - b;
      OP_SLL:   w_quick_res = a << w_shamt;
      OP_SRL:   w_quick_res = a >> w_shamt;
      OP_SRA:   w_quick_res = $signed(a) >>> w_shamt;
      OP_SLT:   w_quick_res = XLEN'(w_lt_s);
      OP_SLTU:  w_quick_res = XLEN'(w_lt_u);
      OP_AND:   w_quick_res = a & b;
      OP_OR:    w_quick_res = a | b;
      OP_XOR:   w_quick_res = a ^ b;
      OP_NOP:   w_quick_res = a;
      OP_CMP:   w_quick_res = w_lt_s ? '1 : (w_eq ? '0 : XLEN'(1));
      OP_CMP_U: w_quick_res = w_lt_u ? '1 : (w_eq ? '0 : XLEN'(1));
      OP_ADDW:  w_quick_res = XLEN'($signed(w_sum32));
      OP_SUBW:  w_quick_res = XLEN'($signed(w_dif32));
      // Only reached on the special paths: b == 0, or signed overflow for DIV/REM.
      OP_DIV:   w_quick_res = w_b_zero ? '1 : a;
      OP_DIVU:  w_quick_res = '1;
      OP_REM:   w_quick_res = w_b_zero ? a : '0;
      OP_REMU:  w_quick_res = a;
      default:  w_quick_res = '0;
    endcase
  end

  muldiv_iter #(
    .XLEN (XLEN)
  ) u_muldiv_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_flush  (flush),
    .i_start  (w_start),
    .i_op     (w_op),
    .i_a      (a),
    .i_b      (b),
    .o_done   (w_iter_done),
    .o_result (w_iter_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  // flush wins over every transition, including an accept in IDLE.
  always_comb begin
    w_state_nx   = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_start      = 1'b0;
    w_load_quick = 1'b0;
    w_load_iter  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (!flush && in_valid) begin
          if (w_quick) begin
            w_state_nx   = ST_DONE;
            w_load_quick = 1'b1;
          end else begin
            w_state_nx = ST_BUSY;
            w_start    = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (flush) begin
          w_state_nx = ST_IDLE;
        end else if (w_iter_done) begin
          w_state_nx  = ST_DONE;
          w_load_iter = 1'b1;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (flush || out_ready) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_res <= '0;
    else if (w_load_quick) r_res <= w_quick_res;
    else if (w_load_iter)  r_res <= w_iter_res;
  end

  assign res  = r_res;
  assign zero = (r_res == '0);

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle (XLEN=64): reference model built from plain arithmetic operators,
// one compare process checking every cycle, directed literal pins plus randomized ops.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [4:0]      alu_op = 5'd0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] res;
  logic            zero;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  alu_multicycle #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .zero      (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference behaviour from the arithmetic rules, using native wide operators.
  function automatic logic [63:0] model(input logic [4:0] op, input logic [63:0] x, input logic [63:0] y);
    logic signed [127:0] ps;
    logic [127:0]        pu;
    logic [31:0]         s32;
    logic                ovf;
    logic [5:0]          sh;
    sh  = y[5:0];
    ovf = (x == 64'h8000_0000_0000_0000) && (y == 64'hFFFF_FFFF_FFFF_FFFF);
    ps  = $signed(x) * $signed(y);
    pu  = {64'd0, x} * {64'd0, y};
    case (op)
      OP_ADD:   return x + y;
      OP_SUB:   return x - y;
      OP_SLL:   return x << sh;
      OP_SRL:   return x >> sh;
      OP_SRA:   return $signed(x) >>> sh;
      OP_SLT:   return {63'd0, $signed(x) < $signed(y)};
      OP_SLTU:  return {63'd0, x < y};
      OP_AND:   return x & y;
      OP_OR:    return x | y;
      OP_XOR:   return x ^ y;
      OP_NOP:   return x;
      OP_CMP:   return ($signed(x) > $signed(y)) ? 64'd1 : (x == y) ? 64'd0 : '1;
      OP_CMP_U: return (x > y) ? 64'd1 : (x == y) ? 64'd0 : '1;
      OP_ADDW:  begin s32 = x[31:0] + y[31:0]; return {{32{s32[31]}}, s32}; end
      OP_SUBW:  begin s32 = x[31:0] - y[31:0]; return {{32{s32[31]}}, s32}; end
      OP_MUL:   return pu[63:0];
      OP_MULH:  return ps[127:64];
      OP_MULHU: return pu[127:64];
      OP_DIV:   return (y == 0) ? '1 : ovf ? x : 64'($signed(x) / $signed(y));
      OP_REM:   return (y == 0) ? x : ovf ? 64'd0 : 64'($signed(x) % $signed(y));
      OP_DIVU:  return (y == 0) ? '1 : x / y;
      OP_REMU:  return (y == 0) ? x : x % y;
      default:  return 64'd0;
    endcase
  endfunction

  function automatic int lat_of(input logic [4:0] op, input logic [63:0] x, input logic [63:0] y);
    logic ovf;
    ovf = (x == 64'h8000_0000_0000_0000) && (y == '1);
    if (op inside {OP_MUL, OP_MULH, OP_MULHU, OP_DIVU, OP_REMU})
      return (op inside {OP_DIVU, OP_REMU} && y == 0) ? 1 : XLEN + 1;
    if (op inside {OP_DIV, OP_REM})
      return (y == 0 || ovf) ? 1 : XLEN + 1;
    return 1;
  endfunction

  // Scoreboard bookkeeping at the active edge.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n || flush) exp_q.delete();
    else begin
      if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) exp_q.push_back('{model(alu_op, a, b), cyc + lat_of(alu_op, a, b)});
    end
  end

  // Compare process: outputs checked every cycle on the falling edge.
  initial begin
    logic prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_ov = 1'b0;
      else begin
        if (exp_q.size() == 0) chk("spurious_valid", 64'(out_valid), 64'd0);
        else begin
          if (cyc == exp_q[0].due) chk("valid_at_due", 64'(out_valid), 64'd1);
          if (out_valid) begin
            chk("res", res, exp_q[0].res);
            chk("zero", 64'(zero), 64'(exp_q[0].res == 64'd0));
            chk("in_ready_in_done", 64'(in_ready), 64'd0);
            if (!prev_ov) chk("latency", 64'(cyc), 64'(exp_q[0].due));
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  function automatic logic [63:0] rand_opd();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'($urandom_range(0, 20));
      4:       return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic issue(input logic [4:0] op, input logic [63:0] x, input logic [63:0] y);
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1; alu_op = op; a = x; b = y;
    @(negedge clk);
    // Scramble inputs after accept: the result must not depend on them.
    in_valid = 1'b0; alu_op = 5'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
  endtask

  task automatic collect(input int stall, output logic [63:0] got, output logic got_z, output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    if (!out_valid) chk("result_timeout", 64'(out_valid), 64'd1);
    got = res; got_z = zero;
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [4:0] op, input logic [63:0] x, input logic [63:0] y,
                        output logic [63:0] got, output logic got_z, output int lat);
    issue(op, x, y);
    collect(0, got, got_z, lat);
  endtask

  initial begin
    logic [63:0] got;
    logic        gz;
    int          lat;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_res", res, 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(OP_ADD, 64'd5, 64'd7, got, gz, lat);
    chk("add_res", got, 64'd12); chk("add_lat", 64'(lat), 64'd1); chk("add_zero", 64'(gz), 64'd0);
    run_op(OP_SLT, '1, 64'd1, got, gz, lat);   chk("slt_res", got, 64'd1);
    run_op(OP_SLTU, '1, 64'd1, got, gz, lat);  chk("sltu_res", got, 64'd0);
    run_op(OP_CMP, 64'd3, 64'd3, got, gz, lat);
    chk("cmp_eq_res", got, 64'd0); chk("cmp_eq_zero", 64'(gz), 64'd1);
    run_op(OP_ADDW, 64'h7FFF_FFFF, 64'd1, got, gz, lat);
    chk("addw_res", got, 64'hFFFF_FFFF_8000_0000);
    run_op(OP_DIV, 64'd100, -64'd7, got, gz, lat);
    chk("div_res", got, -64'd14); chk("div_lat", 64'(lat), 64'd65);
    run_op(OP_REM, 64'd100, -64'd7, got, gz, lat);  chk("rem_res", got, 64'd2);
    run_op(OP_MULH, '1, '1, got, gz, lat);          chk("mulh_res", got, 64'd0);
    run_op(OP_DIVU, 64'd9, 64'd0, got, gz, lat);
    chk("divu0_res", got, '1); chk("divu0_lat", 64'(lat), 64'd1);
    run_op(OP_REMU, 64'd9, 64'd0, got, gz, lat);    chk("remu0_res", got, 64'd9);
    run_op(OP_DIV, 64'h8000_0000_0000_0000, '1, got, gz, lat);
    chk("div_ovf_res", got, 64'h8000_0000_0000_0000); chk("div_ovf_lat", 64'(lat), 64'd1);
    run_op(OP_MUL, 64'h1_0000_0001, 64'd3, got, gz, lat); chk("mul_res", got, 64'h3_0000_0003);
    run_op(5'd31, 64'd5, 64'd7, got, gz, lat);      chk("illegal_res", got, 64'd0);

    // Consumer stalls 3 cycles in DONE.
    issue(OP_SUB, 64'd10, 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk("stall_res", res, 64'd7);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;

    // Flush beats a simultaneous accept.
    in_valid = 1'b1; flush = 1'b1; alu_op = OP_ADD; a = 64'd1; b = 64'd1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_accept_ov", 64'(out_valid), 64'd0);
    chk("flush_accept_ir", 64'(in_ready), 64'd1);

    // Flush in the 10th BUSY cycle.
    issue(OP_DIV, 64'd1000, 64'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_ir", 64'(in_ready), 64'd1);
    chk("flush_busy_ov", 64'(out_valid), 64'd0);
    repeat (70) @(negedge clk);

    // Reset in the middle of BUSY.
    run_op(OP_ADD, 64'd1, 64'd1, got, gz, lat);
    issue(OP_MUL, 64'd12345, 64'd678);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_res", res, 64'd0);
    chk("midrst_zero", 64'(zero), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (70) @(negedge clk);

    // Randomized operations; the compare process checks each result.
    for (int k = 0; k < 250; k++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(22, 31)) : 5'($urandom_range(0, 21));
      issue(op, rand_opd(), rand_opd());
      collect($urandom_range(0, 3), got, gz, lat);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
